// File: rtl/dac_spi_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : dac_spi_sched
//  Description : Round-robin scheduler and 16-bit serialiser for N_DAC
//                DAC121S101 converters sharing one SCLK/DIN bus, with one
//                active-low SYNCn per converter.
//  Revision    : 1.0  initial release
// ============================================================================
module dac_spi_sched #(
   parameter int N_DAC       = 4,
   parameter int CLK_DIV     = 2,
   parameter int SYNC_HI_CYC = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_DAC-1:0]     req_i,
   input  logic [16*N_DAC-1:0]  wdata_i,
   output logic [N_DAC-1:0]     ack_o,
   output logic                 busy_o,
   output logic                 sclk_o,
   output logic                 din_o,
   output logic [N_DAC-1:0]     syncn_o
);

   localparam int PW      = (N_DAC > 1) ? $clog2(N_DAC) : 1;
   localparam int CNT_MAX = (CLK_DIV > SYNC_HI_CYC) ? CLK_DIV : SYNC_HI_CYC;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'((SYNC_HI_CYC > 0) ? SYNC_HI_CYC - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_GRANT = 3'd1,
      S_SETUP = 3'd2,
      S_SHIFT = 3'd3,
      S_CLOSE = 3'd4,
      S_GAP   = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;       // half-period / gap counter
   logic [3:0]        bit_q, bit_d;       // bit index within the frame
   logic              ph_q, ph_d;         // 0: SCLK-low half, 1: SCLK-high half
   logic [1:0]        cph_q, cph_d;       // sub-phase of the frame-close pulse
   logic [15:0]       sr_q, sr_d;
   logic [PW-1:0]     sel_q, sel_d;
   logic [PW-1:0]     ptr_q, ptr_d;
   logic [N_DAC-1:0]  ack_q, ack_d;
   logic              busy_q, busy_d;
   logic              sclk_q, sclk_d;
   logic              din_q, din_d;
   logic [N_DAC-1:0]  syncn_q, syncn_d;

   logic              win_vld;
   logic [PW-1:0]     win_idx;
   logic [PW-1:0]     win_nxt;

   // Round-robin pick: first pending request scanning upward from ptr, wrapping
   always_comb begin : p_arb
      logic [PW-1:0] idx;
      win_vld = 1'b0;
      win_idx = '0;
      idx     = '0;
      for (int i = 0; i < N_DAC; i++) begin
         idx = PW'((int'(ptr_q) + i) % N_DAC);
         if (!win_vld && req_i[idx]) begin
            win_vld = 1'b1;
            win_idx = idx;
         end
      end
      win_nxt = PW'((int'(win_idx) + 1) % N_DAC);
   end

   // Next-state and registered-output logic of the frame sequencer
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      ph_d    = ph_q;
      cph_d   = cph_q;
      sr_d    = sr_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      ack_d   = '0;
      busy_d  = busy_q;
      sclk_d  = sclk_q;
      din_d   = din_q;
      syncn_d = syncn_q;
      unique case (state_q)
         S_IDLE: begin
            // Word is captured here so that ack is visible during GRANT
            if (win_vld) begin
               state_d        = S_GRANT;
               ack_d[win_idx] = 1'b1;
               busy_d         = 1'b1;
               sr_d           = wdata_i[{win_idx, 4'h0} +: 16];
               sel_d          = win_idx;
               ptr_d          = win_nxt;
            end
         end
         S_GRANT: begin
            state_d        = S_SETUP;
            cnt_d          = '0;
            syncn_d[sel_q] = 1'b0;
            sclk_d         = 1'b1;
            din_d          = sr_q[15];
         end
         S_SETUP: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               sclk_d  = 1'b0;
               ph_d    = 1'b0;
               bit_d   = 4'd0;
               state_d = S_SHIFT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_SHIFT: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               if (!ph_q) begin
                  // Rising edge: the only point where DIN may change
                  sclk_d = 1'b1;
                  if (bit_q == 4'd15) begin
                     syncn_d = '1;
                     din_d   = 1'b0;
                     cph_d   = 2'd0;
                     state_d = S_CLOSE;
                  end else begin
                     ph_d  = 1'b1;
                     din_d = sr_q[14];
                     sr_d  = {sr_q[14:0], 1'b0};
                  end
               end else begin
                  sclk_d = 1'b0;
                  ph_d   = 1'b0;
                  bit_d  = bit_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_CLOSE: begin
            // High, low, high: the 17th falling edge, issued with SYNCn high
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               case (cph_q)
                  2'd0: begin
                     sclk_d = 1'b0;
                     cph_d  = 2'd1;
                  end
                  2'd1: begin
                     sclk_d = 1'b1;
                     cph_d  = 2'd2;
                  end
                  default: begin
                     if (SYNC_HI_CYC == 0) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                     end else begin
                        state_d = S_GAP;
                     end
                  end
               endcase
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers; reset aborts any frame in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= 4'd0;
         ph_q    <= 1'b0;
         cph_q   <= 2'd0;
         sr_q    <= 16'h0000;
         sel_q   <= '0;
         ptr_q   <= '0;
         ack_q   <= '0;
         busy_q  <= 1'b0;
         sclk_q  <= 1'b1;
         din_q   <= 1'b0;
         syncn_q <= '1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         ph_q    <= ph_d;
         cph_q   <= cph_d;
         sr_q    <= sr_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
         sclk_q  <= sclk_d;
         din_q   <= din_d;
         syncn_q <= syncn_d;
      end
   end

   assign ack_o   = ack_q;
   assign busy_o  = busy_q;
   assign sclk_o  = sclk_q;
   assign din_o   = din_q;
   assign syncn_o = syncn_q;

endmodule
`default_nettype wire
